// File: rtl/pu_stream_tx.sv
// pu_stream_tx: processing unit that accepts words from the NITTA data bus and
// sends them to an external sink over a valid/ready stream.
//
// Bus side:
//   signal_wr pushes {attr_in, data_in} into a circular buffer of FIFO_SIZE words.
//   signal_oe drives a status word onto the bus. Both outputs are zero when
//   signal_oe is low, so they can be ORed onto the bus:
//     data_out = words held (buffer count + output stage), zero-extended
//     attr_out = {.., tx_valid, empty, full, overflow}
// Stream side:
//   tx_data/tx_attr/tx_valid come from a single output register that the
//   buffer drains into; tx_ready is the sink's accept.
// Ports:
//   clk, rst (synchronous, active-high)
//   data_in, attr_in, signal_wr, signal_oe   bus inputs
//   data_out, attr_out                       bus status outputs
//   tx_data, tx_attr, tx_valid, tx_ready     stream interface
module pu_stream_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int FIFO_SIZE  = 3,
  parameter int ADDR_WIDTH = $clog2(FIFO_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  input  logic                  signal_wr,
  input  logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [ATTR_WIDTH-1:0] tx_attr,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  // Count must represent FIFO_SIZE itself, so it can need one more bit than
  // the pointers (e.g. FIFO_SIZE=4).
  localparam int CNT_WIDTH = $clog2(FIFO_SIZE + 1);
  localparam int WORD_WIDTH = ATTR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(FIFO_SIZE);

  logic [WORD_WIDTH-1:0] mem [FIFO_SIZE];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;

  logic buf_empty;
  logic buf_full;
  logic pop;
  logic push;
  logic ovf_event;

  // Pointers wrap explicitly because FIFO_SIZE need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign buf_empty = (count == '0);
  assign buf_full  = (count == FULL_CNT);

  // The output stage takes a new word whenever it is empty or its current
  // word is being accepted this cycle.
  assign pop       = (!tx_valid || tx_ready) && !buf_empty;
  // A pop frees a slot in the same edge, so a push at full is still accepted.
  assign push      = signal_wr && (!buf_full || pop);
  assign ovf_event = signal_wr && buf_full && !pop;

  // NOTE: the storage array has no reset; validity is tracked solely by
  // count/pointers, so stale contents are never observed and the array can
  // map onto plain RAM/register cells without a reset network.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {attr_in, data_in};
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values, matching the combinational pop/push
  // decisions above regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      tx_attr  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end

      if (pop) begin
        {tx_attr, tx_data} <= mem[rd_ptr];
        tx_valid           <= 1'b1;
        rd_ptr             <= next_ptr(rd_ptr);
      end else if (tx_valid && tx_ready) begin
        // Sink took the last word; data/attr keep their value.
        tx_valid <= 1'b0;
      end

      unique case ({push, pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase

      // A same-edge overflow beats the clear from a status read.
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (signal_oe) begin
        overflow <= 1'b0;
      end
    end
  end

  // NOTE: defaults are assigned first so every path drives every output
  // and no latch is inferred.
  always_comb begin
    data_out = '0;
    attr_out = '0;
    if (signal_oe) begin
      data_out    = DATA_WIDTH'(count) + DATA_WIDTH'(tx_valid);
      attr_out[0] = overflow;
      attr_out[1] = buf_full;
      attr_out[2] = buf_empty && !tx_valid;
      attr_out[3] = tx_valid;
    end
  end

endmodule

// File: tb/tb_pu_stream_tx.sv
// Self-checking bench for pu_stream_tx (default parameters, FIFO_SIZE=3).
// Stimulus pushes expected stream words into a scoreboard queue; a monitor
// on the falling edge pops and compares every accepted stream word and
// checks that a stalled word stays stable.
module tb_pu_stream_tx;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  a;
  } word_t;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [3:0]  attr_in;
  logic        signal_wr;
  logic        signal_oe;
  logic [31:0] data_out;
  logic [3:0]  attr_out;
  logic [31:0] tx_data;
  logic [3:0]  tx_attr;
  logic        tx_valid;
  logic        tx_ready;

  int    n_checks;
  int    n_fail;
  word_t exp_q[$];

  pu_stream_tx dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .attr_in  (attr_in),
    .signal_wr(signal_wr),
    .signal_oe(signal_oe),
    .data_out (data_out),
    .attr_out (attr_out),
    .tx_data  (tx_data),
    .tx_attr  (tx_attr),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp_d, input logic [3:0] exp_a);
    signal_oe = 1'b1;
    #1;
    check({name, "_data_out"}, 64'(data_out), 64'(exp_d));
    check({name, "_attr_out"}, 64'(attr_out), 64'(exp_a));
    signal_oe = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] a, input bit accepted);
    word_t w;
    signal_wr = 1'b1;
    data_in   = d;
    attr_in   = a;
    if (accepted) begin
      w.d = d;
      w.a = a;
      exp_q.push_back(w);
    end
    step();
    signal_wr = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, input bit toggle, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < max_cycles) begin
      tx_ready = toggle ? ~tx_ready : 1'b1;
      step();
      n++;
    end
    check(name, 64'(exp_q.size() == 0 && !tx_valid), 64'd1);
  endtask

  // Monitor: compare accepted words, and check stalled words hold stable.
  logic        hold_pending;
  logic [31:0] held_d;
  logic [3:0]  held_a;

  initial hold_pending = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("stall_valid", 64'(tx_valid), 64'd1);
        check("stall_data", 64'(tx_data), 64'(held_d));
        check("stall_attr", 64'(tx_attr), 64'(held_a));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got data 0x%0h attr 0x%0h, expected none at %0t",
                   tx_data, tx_attr, $time);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("stream_data", 64'(tx_data), 64'(w.d));
          check("stream_attr", 64'(tx_attr), 64'(w.a));
        end
      end
      hold_pending = tx_valid && !tx_ready;
      held_d       = tx_data;
      held_a       = tx_attr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    data_in   = '0;
    attr_in   = '0;
    signal_wr = 1'b0;
    signal_oe = 1'b0;
    tx_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_tx_attr", 64'(tx_attr), 64'd0);
    read_status("rst", 32'd0, 4'b0100);

    // Single word: loads one edge after the push, drops one edge later.
    tx_ready = 1'b1;
    push_word(32'hA5, 4'h3, 1'b1);
    check("single_latency_valid", 64'(tx_valid), 64'd0);
    read_status("single_buffered", 32'd1, 4'b0000);
    step();
    check("single_valid", 64'(tx_valid), 64'd1);
    check("single_data", 64'(tx_data), 64'hA5);
    check("single_attr", 64'(tx_attr), 64'h3);
    step();
    check("single_drop", 64'(tx_valid), 64'd0);
    check("single_hold_data", 64'(tx_data), 64'hA5);
    read_status("single_empty", 32'd0, 4'b0100);

    // Stalled sink: 1..4 held, 5 dropped with overflow.
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push_word(32'(i), 4'(i), i <= 4);
    end
    check("stall_head", 64'(tx_data), 64'd1);
    read_status("ovf", 32'd4, 4'b1011);
    step();
    step();
    check("stall_head_later", 64'(tx_data), 64'd1);

    // Status-read edge with no overflow event clears the flag.
    signal_oe = 1'b1;
    step();
    signal_oe = 1'b0;
    read_status("ovf_cleared", 32'd4, 4'b1010);

    // Full buffer with a pop in the same edge accepts the push.
    tx_ready = 1'b1;
    push_word(32'd9, 4'h9, 1'b1);
    read_status("full_push_pop", 32'd4, 4'b1010);
    wait_drain(30, 1'b0, "drain_after_9");

    // Overflow in the same edge as a status read: set wins.
    tx_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      push_word(32'(i), 4'(i), 1'b1);
    end
    signal_wr = 1'b1;
    data_in   = 32'd15;
    attr_in   = 4'hF;
    signal_oe = 1'b1;
    #1;
    check("pre_edge_data_out", 64'(data_out), 64'd4);
    check("pre_edge_attr_out", 64'(attr_out), 64'b1010);
    step();
    signal_wr = 1'b0;
    signal_oe = 1'b0;
    read_status("ovf_set_wins", 32'd4, 4'b1011);
    wait_drain(30, 1'b0, "drain_after_15");
    read_status("ovf_sticky_empty", 32'd0, 4'b0101);
    signal_oe = 1'b1;
    step();
    signal_oe = 1'b0;
    read_status("ovf_clear_empty", 32'd0, 4'b0100);

    // Seven words with tx_ready toggling: pointer wrap, nothing lost.
    for (int i = 0; i < 7; i++) begin
      tx_ready = (i % 2 == 0);
      push_word(32'(100 + i), 4'(i), 1'b1);
    end
    wait_drain(60, 1'b1, "drain_toggle");

    // Reset mid-handshake discards everything; rst beats signal_wr.
    tx_ready = 1'b0;
    push_word(32'd21, 4'h1, 1'b0);
    push_word(32'd22, 4'h2, 1'b0);
    push_word(32'd23, 4'h3, 1'b0);
    check("pre_rst_valid", 64'(tx_valid), 64'd1);
    read_status("pre_rst", 32'd3, 4'b1000);
    rst       = 1'b1;
    signal_wr = 1'b1;
    data_in   = 32'd99;
    attr_in   = 4'h9;
    signal_oe = 1'b1;
    step();
    rst       = 1'b0;
    signal_wr = 1'b0;
    signal_oe = 1'b0;
    check("mid_rst_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_data", 64'(tx_data), 64'd0);
    check("mid_rst_attr", 64'(tx_attr), 64'd0);
    read_status("post_rst", 32'd0, 4'b0100);
    tx_ready = 1'b1;
    repeat (10) step();
    check("post_rst_silent", 64'(tx_valid), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_stream_tx.md
Name: pu_stream_tx

Overview:
- Processing unit that takes words from the NITTA data bus and transmits them to an external consumer over a valid/ready stream.
- Bus side uses the standard PU strobes: signal_wr pushes {attr_in, data_in} into an internal circular buffer; signal_oe drives a status word onto the bus.
- Stream side drains the buffer through a registered output stage.
- Complements the bus-side FIFO PU: that unit is written and read by the bus; this one is written by the bus and read by an external sink.

Parameters:
- DATA_WIDTH, 32, bus and stream data width.
- ATTR_WIDTH, 4, attribute width; must be >= 4.
- FIFO_SIZE, 3, buffer depth in words; must be >= 2; need not be a power of two.
- ADDR_WIDTH, $clog2(FIFO_SIZE), buffer pointer width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- data_in  input  DATA_WIDTH  bus word to transmit.
- attr_in  input  ATTR_WIDTH  attribute travelling with data_in.
- signal_wr  input  1  push strobe, sampled on posedge clk.
- signal_oe  input  1  status read strobe.
- data_out  output  DATA_WIDTH  status: occupancy, zero-extended.
- attr_out  output  ATTR_WIDTH  status flags.
- tx_data  output  DATA_WIDTH  stream data.
- tx_attr  output  ATTR_WIDTH  stream attribute.
- tx_valid  output  1  stream word present.
- tx_ready  input  1  sink accepts the word.

Behaviour:
- Single clock domain. All state changes occur on posedge clk.
- Reset (rst=1 at an edge):
  - read/write pointers, buffer count and overflow flag go to 0;
  - tx_valid, tx_data and tx_attr go to 0;
  - buffered and in-flight words are discarded, including a word mid-handshake;
  - rst has priority over signal_wr and signal_oe in the same cycle.
- Buffer:
  - FIFO_SIZE entries of {attr, data}; count range 0..FIFO_SIZE;
  - pointers wrap from FIFO_SIZE-1 to 0.
- Output stage (one register, holding tx_data/tx_attr/tx_valid):
  - "pop" = output stage empty, or tx_valid && tx_ready, while the buffer is non-empty;
  - on pop, the stage loads the buffer head, the read pointer advances and tx_valid=1;
  - if tx_valid && tx_ready and the buffer is empty, tx_valid goes to 0 and tx_data/tx_attr hold their value;
  - while tx_valid && !tx_ready, tx_data/tx_attr/tx_valid hold stable.
- Push:
  - signal_wr at edge k, with the buffer not full or a pop at edge k, writes at the write pointer and advances it;
  - first-word latency: a push into an empty unit gives tx_valid=1 after edge k+1 (the stage loads at edge k+1);
  - push and pop in the same edge: both take effect and count is unchanged; this is legal at count == FIFO_SIZE.
- Overflow:
  - signal_wr with the buffer full and no pop: the word is dropped and the overflow flag sets (sticky).
- Status read (combinational):
  - signal_oe=1: data_out = count + tx_valid (total words held, 0..FIFO_SIZE+1), zero-extended;
  - attr_out[0]=overflow, [1]=full (count==FIFO_SIZE), [2]=empty (count==0 && !tx_valid), [3]=tx_valid; upper bits 0;
  - signal_oe=0: data_out and attr_out = 0, so outputs OR onto the bus.
- Overflow clear:
  - an edge with signal_oe=1 clears overflow;
  - if an overflow occurs in that same edge, the set wins.
- Simultaneous signal_wr and signal_oe: both serviced; the status shown reflects the pre-edge state.
- Throughput: one word per cycle sustained with tx_ready held at 1.

Test Plan:
- Reset then push 0xA5 with attr 0x3 at edge k, tx_ready=1 -> tx_valid=1, tx_data=0xA5, tx_attr=0x3 after edge k+1, low after edge k+2; status read with signal_oe=1 shows attr_out[2]=1.
- tx_ready=0, push 1,2,3,4,5 (FIFO_SIZE=3) -> tx_data=1 held stable; status reads data_out=4, attr_out[1]=1, attr_out[0]=1 (word 5 dropped); after raising tx_ready the sink receives 1,2,3,4 in order, then tx_valid=0.
- Buffer full, tx_valid=1, tx_ready=1 and push 9 in the same cycle -> accepted without overflow; 9 arrives last in order.
- Push 7 words with tx_ready toggling 1,0,1,0 -> all 7 words received in order, pointer wrap exercised, no duplicates or losses.
- Overflow set, then an edge with signal_oe=1 and no overflow event -> attr_out[0]=0 on the next read; repeat with an overflow in the same edge -> flag stays 1.
- rst asserted while tx_valid=1, tx_ready=0 and the buffer holds 2 words -> after the edge tx_valid=0, data_out=0 on read, no old word is ever emitted.
